// File: rtl/profile_pkg.sv
// Shared definitions for the profile_player block.
// Declares the channel count, the code width, the FSM state type and the
// field layout of a table entry: {ch3, ch2, ch1, ch0, dwell}.
package profile_pkg;

  localparam int NUM_CH    = 4;
  localparam int PROFILE_W = 3;
  localparam int CODES_W   = NUM_CH * PROFILE_W;

  // The dwell field sits in the low bits of an entry.
  localparam int DWELL_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // The codes field starts directly above the dwell field, with ch0 lowest.
  function automatic int codes_lsb(input int dwell_w);
    return DWELL_LSB + dwell_w;
  endfunction

endpackage

// File: rtl/profile_table.sv
// Simple dual-port RAM holding the step table.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_data write port;
//        i_rd_en/i_rd_addr read port, o_rd_data valid one cycle after the read.
module profile_table #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset branch so it maps onto block RAM; the host
  // table survives a reset of the player.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/profile_player.sv
// Timed profile-pattern transmitter for four DDS channels.
// Replays a host-loaded table; each step presents one 3-bit code per channel
// for max(dwell, MIN_DWELL) cycles.
// Ports: clk, rst (sync, active high); i_wr_en/i_wr_addr/i_wr_data table write;
//        i_num_steps, i_loop_en sampled at start; i_start, i_stop control;
//        o_ch0..o_ch3_profile_ext registered codes; o_busy, o_done, o_step_idx.
module profile_player
  import profile_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DWELL_W   = 16,
  parameter int MIN_DWELL = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
  input  logic [CODES_W+DWELL_W-1:0]   i_wr_data,
  input  logic [$clog2(DEPTH):0]       i_num_steps,
  input  logic                         i_loop_en,
  input  logic                         i_start,
  input  logic                         i_stop,
  output logic [PROFILE_W-1:0]         o_ch0_profile_ext,
  output logic [PROFILE_W-1:0]         o_ch1_profile_ext,
  output logic [PROFILE_W-1:0]         o_ch2_profile_ext,
  output logic [PROFILE_W-1:0]         o_ch3_profile_ext,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(DEPTH)-1:0]     o_step_idx
);

  localparam int AW        = $clog2(DEPTH);
  localparam int ENTRY_W   = CODES_W + DWELL_W;
  localparam int CODES_LSB = codes_lsb(DWELL_W);

  state_e               r_state, w_state_nxt;
  logic [AW-1:0]        r_idx, r_last;
  logic                 r_loop;
  logic [DWELL_W-1:0]   r_cnt;
  logic [CODES_W-1:0]   r_codes;
  logic [ENTRY_W-1:0]   r_buf;
  logic                 r_pf_pend;
  logic                 r_done;

  logic                 w_rd_en;
  logic [AW-1:0]        w_rd_addr;
  logic [ENTRY_W-1:0]   w_rd_data;
  logic                 w_load_first, w_advance, w_finish;
  logic [AW-1:0]        w_last_nxt;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] idx,
                                           input logic [AW-1:0] last);
    return (idx == last) ? '0 : idx + 1'b1;
  endfunction

  // Counter reload value: effective dwell minus one, so cnt=0 marks the final cycle.
  function automatic logic [DWELL_W-1:0] f_eff_m1(input logic [DWELL_W-1:0] dwell);
    if (dwell < DWELL_W'(MIN_DWELL)) return DWELL_W'(MIN_DWELL - 1);
    else                             return dwell - 1'b1;
  endfunction

  profile_table #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_table (
    .clk       (clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Index of the final step: 0 steps plays one, oversize requests clamp to the table.
  always_comb begin
    if (i_num_steps == '0)                       w_last_nxt = '0;
    else if (i_num_steps > (AW+1)'(DEPTH))       w_last_nxt = AW'(DEPTH - 1);
    else                                         w_last_nxt = AW'(i_num_steps - 1'b1);
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    w_load_first = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) begin
          w_rd_en     = 1'b1;
          w_state_nxt = PRIME;
        end
      end
      PRIME: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_load_first = 1'b1;
          w_rd_en      = 1'b1;
          w_rd_addr    = f_next('0, r_last);
          w_state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          if (r_idx == r_last && !r_loop) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            // The step being loaded is next(idx); prefetch the one after it.
            w_advance = 1'b1;
            w_rd_en   = 1'b1;
            w_rd_addr = f_next(f_next(r_idx, r_last), r_last);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_last    <= '0;
      r_loop    <= 1'b0;
      r_cnt     <= '0;
      r_codes   <= '0;
      r_buf     <= '0;
      r_pf_pend <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_finish;
      // Prefetched data lands in the buffer one cycle after its read; every
      // dwell is at least two cycles, so this always precedes the next advance.
      r_pf_pend <= w_rd_en && (r_state != IDLE);
      if (r_pf_pend) r_buf <= w_rd_data;

      if (r_state == IDLE && w_state_nxt == PRIME) begin
        r_last <= w_last_nxt;
        r_loop <= i_loop_en;
        r_idx  <= '0;
      end

      // All twelve code bits load on one edge, so channels never show a mix of steps.
      if (w_load_first) begin
        r_codes <= w_rd_data[CODES_LSB +: CODES_W];
        r_cnt   <= f_eff_m1(w_rd_data[DWELL_LSB +: DWELL_W]);
        r_idx   <= '0;
      end else if (w_advance) begin
        r_codes <= r_buf[CODES_LSB +: CODES_W];
        r_cnt   <= f_eff_m1(r_buf[DWELL_LSB +: DWELL_W]);
        r_idx   <= f_next(r_idx, r_last);
      end else if (r_state == HOLD && !i_stop && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_ch0_profile_ext = r_codes[0*PROFILE_W +: PROFILE_W];
  assign o_ch1_profile_ext = r_codes[1*PROFILE_W +: PROFILE_W];
  assign o_ch2_profile_ext = r_codes[2*PROFILE_W +: PROFILE_W];
  assign o_ch3_profile_ext = r_codes[3*PROFILE_W +: PROFILE_W];
  assign o_busy            = (r_state != IDLE);
  assign o_done            = r_done;
  assign o_step_idx        = r_idx;

endmodule

// File: tb/tb_profile_player.sv
// Directed self-checking bench for profile_player (DEPTH=16, DWELL_W=16, MIN_DWELL=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_profile_player;
  import profile_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_wr_addr = '0;
  logic [27:0] i_wr_data = '0;
  logic [4:0]  i_num_steps = '0;
  logic        i_loop_en = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [2:0]  o_ch0, o_ch1, o_ch2, o_ch3;
  logic        o_busy, o_done;
  logic [3:0]  o_step_idx;
  logic [11:0] w_codes;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected step sequence for run_expect: 12-bit code word, length, step index.
  logic [11:0] exp_code [8];
  int          exp_len  [8];
  int          exp_idx  [8];

  always #5 clk = ~clk;

  assign w_codes = {o_ch3, o_ch2, o_ch1, o_ch0};

  profile_player #(.DEPTH(16), .DWELL_W(16), .MIN_DWELL(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_wr_en           (i_wr_en),
    .i_wr_addr         (i_wr_addr),
    .i_wr_data         (i_wr_data),
    .i_num_steps       (i_num_steps),
    .i_loop_en         (i_loop_en),
    .i_start           (i_start),
    .i_stop            (i_stop),
    .o_ch0_profile_ext (o_ch0),
    .o_ch1_profile_ext (o_ch1),
    .o_ch2_profile_ext (o_ch2),
    .o_ch3_profile_ext (o_ch3),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_step_idx        (o_step_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [11:0] codes,
                             input logic [15:0] dwell);
    i_wr_en   = 1'b1;
    i_wr_addr = addr;
    i_wr_data = {codes, dwell};
    @(negedge clk);
    i_wr_en   = 1'b0;
  endtask

  // Pulses start and returns at the first cycle the entry-0 codes should show.
  task automatic start_run(input string tag, input logic [4:0] ns, input logic loop);
    i_num_steps = ns;
    i_loop_en   = loop;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_busy_prime"}, 32'(o_busy), 32'd1);
    @(negedge clk);
  endtask

  // Checks codes, step index and busy every cycle of the expected sequence.
  // Optionally pulses start or writes the table at a given cycle of the run.
  task automatic run_expect(input string tag, input int n, input int start_at,
                            input int wr_at, input logic [3:0] wa, input logic [27:0] wd);
    int cyc = 0;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < exp_len[s]; c++) begin
        check($sformatf("%s_code_s%0d_c%0d", tag, s, c), 32'(w_codes), 32'(exp_code[s]));
        check($sformatf("%s_idx_s%0d_c%0d", tag, s, c), 32'(o_step_idx), 32'(exp_idx[s]));
        check($sformatf("%s_busy_s%0d_c%0d", tag, s, c), 32'(o_busy), 32'd1);
        i_start   = (cyc == start_at);
        i_wr_en   = (cyc == wr_at);
        i_wr_addr = wa;
        i_wr_data = wd;
        cyc++;
        @(negedge clk);
      end
    end
    i_start = 1'b0;
    i_wr_en = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [11:0] last_code);
    check({tag, "_done"}, 32'(o_done), 32'd1);
    check({tag, "_busy_low"}, 32'(o_busy), 32'd0);
    check({tag, "_code_hold"}, 32'(w_codes), 32'(last_code));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    check({tag, "_code_hold2"}, 32'(w_codes), 32'(last_code));
  endtask

  // Asserts stop for one cycle and checks that the codes freeze without done.
  task automatic stop_and_check(input string tag, input logic [11:0] frozen);
    int done_seen = 0;
    int code_moved = 0;
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    check({tag, "_busy_low"}, 32'(o_busy), 32'd0);
    check({tag, "_frozen"}, 32'(w_codes), 32'(frozen));
    for (int i = 0; i < 8; i++) begin
      if (o_done) done_seen++;
      if (w_codes != frozen) code_moved++;
      @(negedge clk);
    end
    check({tag, "_no_done"}, 32'(done_seen), 32'd0);
    check({tag, "_still_frozen"}, 32'(code_moved), 32'd0);
  endtask

  initial begin
    int done_seen;

    // 1. Reset and idle.
    repeat (3) @(negedge clk);
    check("rst_codes", 32'(w_codes), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_idx", 32'(o_step_idx), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done || o_busy || w_codes != 12'h000) done_seen++;
    end
    check("idle_quiet", 32'(done_seen), 32'd0);

    // Table for the basic pass: ch0 codes 1,2,3 with dwells 5,4,10.
    write_entry(4'd0, 12'h001, 16'd5);
    write_entry(4'd1, 12'h002, 16'd4);
    write_entry(4'd2, 12'h003, 16'd10);

    // Reset in the middle of HOLD.
    start_run("rstmid", 5'd3, 1'b0);
    @(negedge clk);
    check("rstmid_code_before", 32'(w_codes), 32'h001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_codes", 32'(w_codes), 32'd0);
    check("rstmid_busy", 32'(o_busy), 32'd0);
    check("rstmid_idx", 32'(o_step_idx), 32'd0);
    @(negedge clk);

    // 2. Three-step non-looping pass.
    exp_code[0] = 12'h001; exp_len[0] = 5;  exp_idx[0] = 0;
    exp_code[1] = 12'h002; exp_len[1] = 4;  exp_idx[1] = 1;
    exp_code[2] = 12'h003; exp_len[2] = 10; exp_idx[2] = 2;
    start_run("pass3", 5'd3, 1'b0);
    check("pass3_code_latency", 32'(w_codes), 32'h001);
    run_expect("pass3", 3, -1, -1, 4'd0, 28'd0);
    expect_done("pass3", 12'h003);

    // 3. Dwells below MIN_DWELL are stretched to 4 cycles.
    write_entry(4'd0, 12'h004, 16'd0);
    write_entry(4'd1, 12'h005, 16'd1);
    exp_code[0] = 12'h004; exp_len[0] = 4; exp_idx[0] = 0;
    exp_code[1] = 12'h005; exp_len[1] = 4; exp_idx[1] = 1;
    start_run("mindw", 5'd2, 1'b0);
    run_expect("mindw", 2, -1, -1, 4'd0, 28'd0);
    expect_done("mindw", 12'h005);

    // 4. Two-step loop with wrap, then stop mid-step.
    write_entry(4'd0, 12'h006, 16'd6);
    write_entry(4'd1, 12'h007, 16'd6);
    exp_code[0] = 12'h006; exp_len[0] = 6; exp_idx[0] = 0;
    exp_code[1] = 12'h007; exp_len[1] = 6; exp_idx[1] = 1;
    exp_code[2] = 12'h006; exp_len[2] = 6; exp_idx[2] = 0;
    exp_code[3] = 12'h007; exp_len[3] = 3; exp_idx[3] = 1;
    start_run("loop", 5'd2, 1'b1);
    run_expect("loop", 4, -1, -1, 4'd0, 28'd0);
    stop_and_check("loop_stop", 12'h007);

    // 5a. start together with stop in IDLE stays idle.
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("startstop_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("startstop_busy2", 32'(o_busy), 32'd0);
    check("startstop_codes", 32'(w_codes), 32'h007);

    // 5b. num_steps=0 plays one step; a start pulse during HOLD is ignored.
    write_entry(4'd0, 12'h002, 16'd5);
    exp_code[0] = 12'h002; exp_len[0] = 5; exp_idx[0] = 0;
    start_run("ns0", 5'd0, 1'b0);
    run_expect("ns0", 1, 2, -1, 4'd0, 28'd0);
    expect_done("ns0", 12'h002);

    // 6. Rewrite entry 0 during a loop before its prefetch; all channels change together.
    write_entry(4'd0, 12'h249, 16'd5);
    write_entry(4'd1, 12'hDB6, 16'd5);
    exp_code[0] = 12'h249; exp_len[0] = 5; exp_idx[0] = 0;
    exp_code[1] = 12'hDB6; exp_len[1] = 5; exp_idx[1] = 1;
    exp_code[2] = 12'hAD4; exp_len[2] = 5; exp_idx[2] = 0;
    exp_code[3] = 12'hDB6; exp_len[3] = 2; exp_idx[3] = 1;
    start_run("rewr", 5'd2, 1'b1);
    run_expect("rewr", 4, -1, 1, 4'd0, {12'hAD4, 16'd5});
    stop_and_check("rewr_stop", 12'hDB6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
